// File: rtl/pp_mul_pkg.sv
// Shared types and helpers for the pp_pipeline_accel multiply/MAC stream unit.
// fits() drives out_ovf; sat() clamps results when PP_MUL_SAT_EN is defined.
package pp_mul_pkg;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_MAC = 1'b1
  } mode_e;

  // Scaled results are widened to MAXW before range checks; ACC_WIDTH must not exceed it.
  localparam int unsigned MAXW = 128;

  function automatic logic fits(input logic [MAXW-1:0] s, input int unsigned width,
                                input logic sgn);
    logic        top;
    int unsigned lo;
    logic        ok;
    top = sgn & s[MAXW-1];
    lo  = sgn ? width - 1 : width;
    ok  = 1'b1;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i >= lo && s[i] != top) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [MAXW-1:0] sat(input logic [MAXW-1:0] s, input int unsigned width,
                                          input logic sgn);
    logic [MAXW-1:0] mask;
    mask = ~({MAXW{1'b1}} << width);
    if (!sgn) return mask;
    if (s[MAXW-1]) return ~(mask >> 1);
    return mask >> 1;
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_mul_core.sv
// ce-gated operand/product register chain (NUM_STAGE-1 deep) with valid/mode/last sidebands.
// Stage 1 holds operands; stages 2..NUM_STAGE-1 hold the sign-correct full product.
module pp_pipeline_accel_mul_core #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 11,
  parameter int unsigned A_SIGNED  = 0,
  parameter int unsigned B_SIGNED  = 0,
  parameter int unsigned NUM_STAGE = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         in_a,
  input  logic [B_WIDTH-1:0]         in_b,
  input  logic                       in_mode,
  input  logic                       in_last,
  output logic                       st_valid,
  output logic                       st_mode,
  output logic                       st_last,
  output logic [A_WIDTH+B_WIDTH:0]   st_prod
);

  localparam int unsigned PRW = A_WIDTH + B_WIDTH + 1;
  localparam int unsigned PD  = NUM_STAGE - 2;

  logic [A_WIDTH-1:0] s1_a;
  logic [B_WIDTH-1:0] s1_b;
  logic               s1_valid, s1_mode, s1_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
    end else if (ce) begin
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_last  <= in_last;
    end
  end

  // One extra bit per operand turns mixed signedness into a plain signed multiply.
  logic signed [A_WIDTH:0]         ax;
  logic signed [B_WIDTH:0]         bx;
  logic signed [A_WIDTH+B_WIDTH+1:0] full;
  logic [PRW-1:0]                  prod0;

  assign ax    = {(A_SIGNED != 0) ? s1_a[A_WIDTH-1] : 1'b0, s1_a};
  assign bx    = {(B_SIGNED != 0) ? s1_b[B_WIDTH-1] : 1'b0, s1_b};
  assign full  = ax * bx;
  assign prod0 = full[PRW-1:0];

  if (PD == 0) begin : g_direct
    assign st_prod  = prod0;
    assign st_valid = s1_valid;
    assign st_mode  = s1_mode;
    assign st_last  = s1_last;
  end else begin : g_chain
    logic [PRW-1:0] p_q [PD];
    logic [PD-1:0]  v_q, m_q, l_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        p_q <= '{default: '0};
        v_q <= '0;
        m_q <= '0;
        l_q <= '0;
      end else if (ce) begin
        p_q[0] <= prod0;
        v_q[0] <= s1_valid;
        m_q[0] <= s1_mode;
        l_q[0] <= s1_last;
        for (int unsigned i = 1; i < PD; i++) begin
          p_q[i] <= p_q[i-1];
          v_q[i] <= v_q[i-1];
          m_q[i] <= m_q[i-1];
          l_q[i] <= l_q[i-1];
        end
      end
    end

    assign st_prod  = p_q[PD-1];
    assign st_valid = v_q[PD-1];
    assign st_mode  = m_q[PD-1];
    assign st_last  = l_q[PD-1];
  end

endmodule

// File: rtl/pp_pipeline_accel_mul_stream.sv
// Pipelined MUL/MAC unit with valid/ready backpressure, last-delimited accumulation and scaling.
// Optional output saturation is enabled by defining PP_MUL_SAT_EN.
module pp_pipeline_accel_mul_stream #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 11,
  parameter int unsigned A_SIGNED  = 0,
  parameter int unsigned B_SIGNED  = 0,
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned P_WIDTH   = 27,
  parameter int unsigned NUM_STAGE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_a,
  input  logic [B_WIDTH-1:0] in_b,
  input  logic               in_mode,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_p,
  output logic               out_ovf
);

  import pp_mul_pkg::*;

  localparam int unsigned PRW        = A_WIDTH + B_WIDTH + 1;
  localparam logic        OUT_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

  logic adv;
  assign adv      = ce && (!out_valid || out_ready);
  assign in_ready = adv;

  logic           st_valid, st_mode, st_last;
  logic [PRW-1:0] st_prod;

  pp_pipeline_accel_mul_core #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED),
    .NUM_STAGE(NUM_STAGE)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .ce      (adv),
    .in_valid(in_valid),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_mode (in_mode),
    .in_last (in_last),
    .st_valid(st_valid),
    .st_mode (st_mode),
    .st_last (st_last),
    .st_prod (st_prod)
  );

  logic [ACC_WIDTH-1:0] acc, prod_ext, r, s;
  logic [MAXW-1:0]      s_ext;
  logic                 acc_open, emit, ovf;
  logic [P_WIDTH-1:0]   p_next;

  always_comb begin
    prod_ext = ACC_WIDTH'($signed(st_prod));
    r        = prod_ext;
    if (st_mode == MODE_MAC) r = (acc_open ? acc : '0) + prod_ext;
    if (OUT_SIGNED) begin
      s     = ACC_WIDTH'($signed(r) >>> SHIFT);
      s_ext = MAXW'($signed(s));
    end else begin
      s     = r >> SHIFT;
      s_ext = MAXW'(s);
    end
    ovf  = !fits(s_ext, P_WIDTH, OUT_SIGNED);
    emit = st_valid && (st_mode == MODE_MUL || st_last);
`ifdef PP_MUL_SAT_EN
    p_next = ovf ? P_WIDTH'(sat(s_ext, P_WIDTH, OUT_SIGNED)) : P_WIDTH'(s_ext);
`else
    p_next = P_WIDTH'(s_ext);
`endif
  end

  // MUL beats bypass the accumulator so an open MAC group survives interleaved products.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      acc_open  <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      if (st_valid && st_mode == MODE_MAC) begin
        acc      <= r;
        acc_open <= !st_last;
      end
      out_valid <= emit;
      if (emit) begin
        out_p   <= p_next;
        out_ovf <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_mul_stream.sv
// Scoreboard bench for pp_pipeline_accel_mul_stream: default unsigned instance plus an 8x8 signed one.
module tb_pp_pipeline_accel_mul_stream;

  localparam int unsigned PW = 27;
  localparam longint unsigned ACC_MASK = (64'd1 << 40) - 1;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, in_ready, in_mode, in_last;
  logic        out_valid, out_ready, out_ovf;
  logic [15:0] in_a;
  logic [10:0] in_b;
  logic [26:0] out_p;

  logic        s_valid, s_ready, s_out_valid, s_ovf;
  logic [7:0]  s_a, s_b, s_p;

  always #5 clk = ~clk;

  pp_pipeline_accel_mul_stream dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_ovf(out_ovf)
  );

  pp_pipeline_accel_mul_stream #(
    .A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(1), .B_SIGNED(1),
    .ACC_WIDTH(20), .SHIFT(0), .P_WIDTH(8), .NUM_STAGE(3)
  ) dut_s (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_mode(1'b0), .in_last(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_p(s_p), .out_ovf(s_ovf)
  );

  typedef struct {
    logic [26:0] p;
    logic        ovf;
  } exp_t;

  exp_t            sb[$];
  int              vectors = 0;
  int              miscompares = 0;
  longint unsigned m_acc = 0;
  bit              m_open = 1'b0;
  bit              last_acc;
  int unsigned     cyc = 0;
  int              rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: acts on beats in acceptance order; the pipe is in-order so this suffices.
  task automatic model_accept(input logic [15:0] a, input logic [10:0] b, input logic m,
                              input logic l);
    longint unsigned prod, v;
    exp_t e;
    prod = longint'(a) * longint'(b);
    if (m == 1'b0) begin
      v = prod;
    end else begin
      v = ((m_open ? m_acc : 64'd0) + prod) & ACC_MASK;
      m_acc  = v;
      m_open = !l;
      if (!l) return;
    end
    e.ovf = (v >= (64'd1 << PW));
`ifdef PP_MUL_SAT_EN
    e.p = e.ovf ? 27'h7FFFFFF : v[26:0];
`else
    e.p = v[26:0];
`endif
    sb.push_back(e);
  endtask

  function automatic logic next_rdy();
    logic [3:0] pat;
    pat = 4'b1001;
    case (rdy_mode)
      0:       return 1'b1;
      1:       return pat[cyc % 4];
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic cycle(input logic v, input logic [15:0] a, input logic [10:0] b,
                       input logic m, input logic l, input logic ordy, input logic c);
    @(negedge clk);
    cyc++;
    in_valid = v; in_a = a; in_b = b; in_mode = m; in_last = l;
    out_ready = ordy; ce = c;
    #1;
    last_acc = !reset && v && in_ready;
    if (last_acc) model_accept(a, b, m, l);
  endtask

  task automatic idle();
    cycle(1'b0, 16'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic send(input logic [15:0] a, input logic [10:0] b, input logic m, input logic l);
    for (int t = 0; t < 64; t++) begin
      cycle(1'b1, a, b, m, l, next_rdy(), 1'b1);
      if (last_acc) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: beat not accepted within 64 cycles");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    sb.delete();
    m_open = 1'b0;
    m_acc  = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic scycle(input logic v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    s_valid = v; s_a = a; s_b = b;
    in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks freeze/ready behaviour.
  initial begin
    logic        prev_freeze, prev_v, prev_ovf, exp_rdy;
    logic [26:0] prev_p;
    exp_t        e;
    prev_freeze = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_freeze = 1'b0;
      end else begin
        if (prev_freeze) begin
          check("hold_valid", out_valid, prev_v);
          check("hold_p", out_p, prev_p);
          check("hold_ovf", out_ovf, prev_ovf);
        end
        exp_rdy = ce && !(out_valid && !out_ready);
        check("in_ready", in_ready, exp_rdy);
        if (out_valid && out_ready && ce) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got p=0x%0h, want no output", out_p);
          end else begin
            e = sb.pop_front();
            check("out_p", out_p, e.p);
            check("out_ovf", out_ovf, e.ovf);
          end
        end
        prev_freeze = !ce || (out_valid && !out_ready);
        prev_v   = out_valid;
        prev_p   = out_p;
        prev_ovf = out_ovf;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          pr;
    logic [7:0]  sa, sbv, sexp;
    logic        sovf;
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // Latency and the maximum unsigned product.
    cycle(1'b1, 16'hFFFF, 11'h7FF, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(); idle();
    check("lat_early", out_valid, 0);
    idle();
    check("lat_valid", out_valid, 1);
    check("mul_max_p", out_p, 27'h7FEF801);
    check("mul_max_ovf", out_ovf, 0);

    // MAC group 2*3 + 4*5 + 6*7 = 68.
    cycle(1'b1, 16'd2, 11'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'd4, 11'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'd6, 11'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(); check("mac_no_out1", out_valid, 0);
    idle(); check("mac_no_out2", out_valid, 0);
    idle(); check("mac_valid", out_valid, 1); check("mac_sum", out_p, 68);

    // MUL interleaved inside an open MAC group.
    cycle(1'b1, 16'd10, 11'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'd2, 11'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'd1, 11'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(); idle(); check("ilv_mul", out_p, 4);
    idle(); check("ilv_mac", out_p, 101);

    // Backpressure with out_ready pattern 1,0,0,1.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(16'($urandom), 11'($urandom), 1'b0, 1'b0);
    rdy_mode = 0;
    repeat (5) idle();

    // Reset in the middle of a MAC group.
    send(16'd7, 11'd7, 1'b1, 1'b0);
    send(16'd5, 11'd5, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 16'd3, 11'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(); idle(); idle();
    check("post_rst_mac", out_p, 9);

    // ce low for 5 cycles with results in flight.
    send(16'd11, 11'd13, 1'b0, 1'b0);
    send(16'd17, 11'd19, 1'b0, 1'b0);
    cycle(1'b1, 16'd23, 11'd29, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 16'd99, 11'd99, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) idle();

    // Randomised traffic with random backpressure and ce.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 11'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, next_rdy(), $urandom_range(0, 19) != 0);
    end
    rdy_mode = 0;
    repeat (10) idle();
    check("drain_empty", sb.size(), 0);

    // Signed 8x8 instance, including the (-128)*(-128) overflow corner.
    for (int i = 0; i < 17; i++) begin
      sa  = (i == 0) ? 8'h80 : 8'($urandom);
      sbv = (i == 0) ? 8'h80 : 8'($urandom);
      pr  = int'($signed(sa)) * int'($signed(sbv));
      sovf = (pr > 127) || (pr < -128);
`ifdef PP_MUL_SAT_EN
      sexp = sovf ? ((pr < 0) ? 8'h80 : 8'h7F) : pr[7:0];
`else
      sexp = pr[7:0];
`endif
      scycle(1'b1, sa, sbv);
      scycle(1'b0, 8'd0, 8'd0);
      scycle(1'b0, 8'd0, 8'd0);
      check("s_lat_early", s_out_valid, 0);
      scycle(1'b0, 8'd0, 8'd0);
      check("s_valid", s_out_valid, 1);
      check("s_p", s_p, sexp);
      check("s_ovf", s_ovf, sovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
